div_operand_align: RTL and testbench

DIV_OPERAND_ALIGN -- requirements
Module: div_operand_align

---
 rtl/div_operand_align.sv | 143 ++++++++++++++
 tb/tb_div_operand_align.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_operand_align.sv
// Pairs each dividend with the reciprocal of its divisor returned by a fixed-latency unit.
// Latency: first out_valid LAT+2 cycles after accept; in_ready drops at DEPTH outstanding or while draining.
module div_operand_align #(
    parameter int DEPTH = 16,
    parameter int LAT   = 9
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        rec_valid,
    output logic [31:0] rec_data,
    input  logic        rec_result_valid,
    input  logic [31:0] rec_result_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_recip,
    output logic        out_dbz,
    output logic        align_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int DW = $clog2(LAT + 2);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [DW-1:0] DRAIN_CYC = DW'(LAT + 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] r_res_cnt;
    logic [PW-1:0] r_div_wr;
    logic [PW-1:0] r_div_rd;
    logic [PW-1:0] r_res_wr;
    logic [PW-1:0] r_res_rd;
    logic [32:0]   r_div_mem [DEPTH];
    logic [31:0]   r_res_mem [DEPTH];
    logic [DW-1:0] r_drain_cnt;
    logic          r_rec_vld;
    logic [31:0]   r_rec_dat;
    logic          r_out_vld;
    logic [31:0]   r_out_a;
    logic [31:0]   r_out_recip;
    logic          r_out_dbz;
    logic          r_align_err;

    logic          w_draining;
    logic          w_acc;
    logic          w_pop;
    logic          w_res_req;
    logic          w_res_drop;
    logic          w_res_wr;
    logic          w_dbz;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_res_cnt_nxt;
    logic [CW-1:0] w_div_left;
    logic [CW-1:0] w_res_left;
    logic [PW-1:0] w_div_rd_nxt;
    logic [PW-1:0] w_res_rd_nxt;
    logic [32:0]   w_div_head;
    logic [31:0]   w_res_head;
    logic          w_out_vld_nxt;

    // Results still in flight from before reset come back during the drain window and are discarded.
    assign w_draining = (r_drain_cnt != '0);
    assign in_ready   = (r_count < FULL_CNT) && !w_draining && nRST;

    always_comb begin
        w_acc         = in_valid && in_ready;
        w_pop         = r_out_vld && out_ready;
        w_dbz         = (in_b[30:0] == 31'd0);
        w_res_req     = rec_result_valid && !w_draining;
        w_res_drop    = w_res_req && ((r_count == '0) || (r_res_cnt == FULL_CNT));
        w_res_wr      = w_res_req && !w_res_drop;
        w_div_left    = r_count - CW'(w_pop);
        w_res_left    = r_res_cnt - CW'(w_pop);
        w_count_nxt   = w_div_left + CW'(w_acc);
        w_res_cnt_nxt = w_res_left + CW'(w_res_wr);
        w_div_rd_nxt  = r_div_rd + PW'(w_pop);
        w_res_rd_nxt  = r_res_rd + PW'(w_pop);
        w_out_vld_nxt = (w_count_nxt != '0) && (w_res_cnt_nxt != '0);
        // An entry written into an otherwise-empty FIFO becomes the head in the same cycle.
        w_div_head    = (w_acc && (w_div_left == '0)) ? {in_a, w_dbz} : r_div_mem[w_div_rd_nxt];
        w_res_head    = (w_res_wr && (w_res_left == '0)) ? rec_result_data : r_res_mem[w_res_rd_nxt];
    end

    always_ff @(posedge CLK) begin
        if (w_acc) begin
            r_div_mem[r_div_wr] <= {in_a, w_dbz};
        end
        if (w_res_wr) begin
            r_res_mem[r_res_wr] <= rec_result_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_count     <= '0;
            r_res_cnt   <= '0;
            r_div_wr    <= '0;
            r_div_rd    <= '0;
            r_res_wr    <= '0;
            r_res_rd    <= '0;
            r_drain_cnt <= DRAIN_CYC;
            r_rec_vld   <= 1'b0;
            r_rec_dat   <= '0;
            r_out_vld   <= 1'b0;
            r_out_a     <= '0;
            r_out_recip <= '0;
            r_out_dbz   <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            if (w_draining) begin
                r_drain_cnt <= r_drain_cnt - DW'(1);
            end
            r_count     <= w_count_nxt;
            r_res_cnt   <= w_res_cnt_nxt;
            r_div_wr    <= r_div_wr + PW'(w_acc);
            r_res_wr    <= r_res_wr + PW'(w_res_wr);
            r_div_rd    <= w_div_rd_nxt;
            r_res_rd    <= w_res_rd_nxt;
            r_rec_vld   <= w_acc;
            if (w_acc) begin
                r_rec_dat <= in_b;
            end
            r_out_vld   <= w_out_vld_nxt;
            r_out_a     <= w_out_vld_nxt ? w_div_head[32:1] : 32'd0;
            r_out_dbz   <= w_out_vld_nxt ? w_div_head[0]    : 1'b0;
            r_out_recip <= w_out_vld_nxt ? w_res_head       : 32'd0;
            r_align_err <= r_align_err || w_res_drop;
        end
    end

    assign rec_valid = r_rec_vld;
    assign rec_data  = r_rec_dat;
    assign out_valid = r_out_vld;
    assign out_a     = r_out_a;
    assign out_recip = r_out_recip;
    assign out_dbz   = r_out_dbz;
    assign align_err = r_align_err;

endmodule

// File: tb/tb_div_operand_align.sv
// Directed bench for div_operand_align with a fixed-latency reciprocal model and an in-order scoreboard.
module tb_div_operand_align;

    localparam int DEPTH = 16;
    localparam int LAT   = 9;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        rec_valid;
    logic [31:0] rec_data;
    logic        rec_result_valid;
    logic [31:0] rec_result_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_a;
    logic [31:0] out_recip;
    logic        out_dbz;
    logic        align_err;

    div_operand_align #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .rec_valid(rec_valid), .rec_data(rec_data),
        .rec_result_valid(rec_result_valid), .rec_result_data(rec_result_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_recip(out_recip), .out_dbz(out_dbz), .align_err(align_err)
    );

    always #5 CLK = ~CLK;

    // Reciprocal unit model: "1/b" is b ^ 0x7F000000 (0x40000000 -> 0x3F000000); never reset.
    logic [LAT-1:0]       pv = '0;
    logic [LAT-1:0][31:0] pd = '0;
    logic                 inj_vld = 1'b0;
    logic [31:0]          inj_dat = '0;

    always @(posedge CLK) begin
        pv <= {pv[LAT-2:0], rec_valid};
        pd <= {pd[LAT-2:0], rec_data ^ 32'h7F00_0000};
    end

    assign rec_result_valid = pv[LAT-1] | inj_vld;
    assign rec_result_data  = inj_vld ? inj_dat : pd[LAT-1];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] r;
        logic        z;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic chk_occ = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic at_neg();
        exp_t e;
        @(negedge CLK);
        if (chk_occ) chk("rdy_vs_occ", {31'b0, in_ready}, {31'b0, (sb.size() < DEPTH)});
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("pop_unexpected", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out_a", out_a, e.a);
                chk("out_recip", out_recip, e.r);
                chk("out_dbz", {31'b0, out_dbz}, {31'b0, e.z});
            end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) begin
            e.a = in_a;
            e.r = in_b ^ 32'h7F00_0000;
            e.z = (in_b[30:0] == 31'd0);
            sb.push_back(e);
        end
    endtask

    task automatic to_pos();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        at_neg();
        to_pos();
    endtask

    task automatic drain_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("sb_drain", sb.size(), 32'd0);
    endtask

    task automatic release_drain();
        nRST = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            at_neg();
            chk("drain_rdy", {31'b0, in_ready}, 32'd0);
            chk("drain_ovld", {31'b0, out_valid}, 32'd0);
            chk("drain_err", {31'b0, align_err}, 32'd0);
            to_pos();
        end
        at_neg();
        chk("rdy_after_drain", {31'b0, in_ready}, 32'd1);
        to_pos();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        tick();
        release_drain();
    endtask

    initial begin
        // Reset values
        nRST = 1'b0;
        repeat (2) tick();
        at_neg();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_rec_valid", {31'b0, rec_valid}, 32'd0);
        chk("rst_rec_data", rec_data, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_recip", out_recip, 32'd0);
        chk("rst_out_dbz", {31'b0, out_dbz}, 32'd0);
        chk("rst_align_err", {31'b0, align_err}, 32'd0);
        to_pos();
        release_drain();

        // Single operation: latency and data
        in_valid = 1'b1;
        in_a = 32'h40C0_0000;
        in_b = 32'h4000_0000;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            at_neg();
            if (k == 1) begin
                chk("rec_valid_t1", {31'b0, rec_valid}, 32'd1);
                chk("rec_data_t1", rec_data, 32'h4000_0000);
            end
            if (k == 2) chk("rec_valid_t2", {31'b0, rec_valid}, 32'd0);
            chk("single_early", {31'b0, out_valid}, 32'd0);
            to_pos();
        end
        at_neg();
        chk("single_vld", {31'b0, out_valid}, 32'd1);
        chk("single_a", out_a, 32'h40C0_0000);
        chk("single_recip", out_recip, 32'h3F00_0000);
        chk("single_dbz", {31'b0, out_dbz}, 32'd0);
        to_pos();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        at_neg();
        chk("single_after_pop", {31'b0, out_valid}, 32'd0);
        to_pos();

        // Fill to DEPTH with output stalled, then burst out
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_a = 32'h1000_0000 + i;
            in_b = 32'h4000_0000 | (i << 8);
            at_neg();
            chk("fill_rdy", {31'b0, in_ready}, {31'b0, (i < DEPTH)});
            to_pos();
        end
        in_valid = 1'b0;
        repeat (LAT + 2) tick();
        at_neg();
        chk("stall_vld", {31'b0, out_valid}, 32'd1);
        chk("stall_a0", out_a, sb[0].a);
        to_pos();
        tick();
        at_neg();
        chk("stall_a_hold", out_a, sb[0].a);
        chk("stall_r_hold", out_recip, sb[0].r);
        chk("stall_rdy", {31'b0, in_ready}, 32'd0);
        to_pos();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            at_neg();
            chk("burst_vld", {31'b0, out_valid}, 32'd1);
            to_pos();
        end
        at_neg();
        chk("burst_end_vld", {31'b0, out_valid}, 32'd0);
        chk("burst_end_rdy", {31'b0, in_ready}, 32'd1);
        chk("burst_sb", sb.size(), 32'd0);
        to_pos();

        // Divide by zero next to a normal divisor
        in_valid = 1'b1;
        in_a = 32'h3F80_0000;
        in_b = 32'h8000_0000;
        tick();
        in_a = 32'h4040_0000;
        in_b = 32'h3F80_0000;
        tick();
        in_valid = 1'b0;
        drain_sb(30);
        chk("dbz_err", {31'b0, align_err}, 32'd0);

        // Reset with five operations in flight
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a = 32'h5000_0000 + i;
            in_b = 32'h4100_0000 + i;
            tick();
        end
        do_reset();
        repeat (6) begin
            at_neg();
            chk("post_rst_ovld", {31'b0, out_valid}, 32'd0);
            chk("post_rst_err", {31'b0, align_err}, 32'd0);
            to_pos();
        end

        // Spurious result on an idle block
        inj_vld = 1'b1;
        inj_dat = 32'h1234_5678;
        tick();
        inj_vld = 1'b0;
        at_neg();
        chk("spur_err", {31'b0, align_err}, 32'd1);
        chk("spur_ovld", {31'b0, out_valid}, 32'd0);
        to_pos();
        repeat (3) tick();
        at_neg();
        chk("spur_sticky", {31'b0, align_err}, 32'd1);
        chk("spur_ovld2", {31'b0, out_valid}, 32'd0);
        to_pos();
        do_reset();

        // Concurrent accept and pop with random backpressure
        chk_occ = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_a = $urandom;
            in_b = $urandom;
            if ($urandom_range(0, 3) == 0) in_b[30:0] = '0;
            out_ready = $urandom_range(0, 1) == 1;
            tick();
        end
        chk_occ = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain_sb(60);
        chk("rand_err", {31'b0, align_err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
